fetch_queue: RTL and testbench

Parametrised successor to the single-cycle fetch stage: owns the fetch PC, drives the synchronous instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry queue. The queue faces decode through a valid/ready handshake, replacing the global stall. Sits between the PC-redirect sources (branch, JAL, JALR from execute) and decode. Sustains one instruction per cycle when decode is always ready.

---
 rtl/fetch_pkg.sv | 55 +++++
 rtl/fetch_queue_if.sv | 25 ++
 rtl/fetch_fifo.sv | 77 +++++++
 rtl/fetch_queue.sv | 108 ++++++++++
 tb/tb_fetch_queue.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch queue: entry layout, redirect
// source encoding and redirect target selection.
package fetch_pkg;

  // Datapath width of a queue entry; fetch_queue's XLEN must match it.
  localparam int FQ_XLEN = 32;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] inst;
  } fq_entry_t;

  typedef enum logic [1:0] {
    RS_NONE = 2'd0,
    RS_SB   = 2'd1,
    RS_UJ   = 2'd2,
    RS_JALR = 2'd3
  } redirect_src_e;

  // Resolve simultaneous redirect requests: JALR wins over JAL wins over branch.
  function automatic redirect_src_e redirect_select(input logic jalr,
                                                    input logic uj_en,
                                                    input logic b_en);
    redirect_src_e src;
    if (jalr) begin
      src = RS_JALR;
    end else if (uj_en) begin
      src = RS_UJ;
    end else if (b_en) begin
      src = RS_SB;
    end else begin
      src = RS_NONE;
    end
    return src;
  endfunction

  // Compute the new fetch PC; the low two bits are forced to zero because
  // fetch is always word aligned (no misalignment trap is raised).
  function automatic logic [FQ_XLEN-1:0] redirect_target(
      input redirect_src_e      src,
      input logic [FQ_XLEN-1:0] branch_pc,
      input logic [FQ_XLEN-1:0] al,
      input logic [FQ_XLEN-1:0] uj_imm,
      input logic [FQ_XLEN-1:0] sb_imm);
    logic [FQ_XLEN-1:0] tgt;
    case (src)
      RS_JALR: tgt = al & ~{{(FQ_XLEN-1){1'b0}}, 1'b1};
      RS_UJ:   tgt = branch_pc + uj_imm;
      RS_SB:   tgt = branch_pc + sb_imm;
      default: tgt = '0;
    endcase
    return {tgt[FQ_XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory port plus the valid/ready link towards decode.
interface fetch_queue_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
);
  logic              imem_en;
  logic [ADDR_W-1:0] imem_adr;
  logic [XLEN-1:0]   imem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_inst;
  logic [XLEN-1:0]   out_pc;

  // Fetch side: drives memory requests and the decode-facing head.
  modport master (
    output imem_en, imem_adr, out_valid, out_inst, out_pc,
    input  imem_rdata, out_ready
  );

  // Environment side: memory responder and decode consumer.
  modport slave (
    input  imem_en, imem_adr, out_valid, out_inst, out_pc,
    output imem_rdata, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, inst} entries with flush. The head is read
// straight out of the storage flops, so it is valid the cycle after a push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  fq_entry_t  push_entry,
  input  logic       pop,
  input  logic       flush,
  output fq_entry_t  head,
  output logic [PTR_W:0] count
);

  fq_entry_t        mem_q [DEPTH];
  fq_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_pop_s;

  // Next-state for storage, pointers and occupancy; flush overrides everything.
  always_comb begin
    mem_d    = mem_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    do_pop_s = pop && (cnt_q != '0);
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_entry;
        wr_d        = wr_q + PTR_W'(1);
      end else begin
        wr_d = wr_q;
      end
      if (do_pop_s) begin
        rd_d = rd_q + PTR_W'(1);
      end else begin
        rd_d = rd_q;
      end
      case ({push, do_pop_s})
        2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, issues word reads to a 1-cycle synchronous
// instruction memory and buffers the returned instructions for decode.
// At most one read is outstanding; issue is gated by a credit check so the
// queue can never overflow.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = FQ_XLEN,
  parameter int              ADDR_W   = 12,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            b_en,
  input  logic            UJ_en,
  input  logic            jalr,
  input  logic [XLEN-1:0] branch_pc,
  input  logic [XLEN-1:0] al,
  input  logic [XLEN-1:0] UJimm,
  input  logic [XLEN-1:0] SBimm,
  fetch_queue_if.master   bus
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [XLEN-1:0]  fpc_q, fpc_d;
  logic [XLEN-1:0]  req_pc_q, req_pc_d;
  logic             inflight_q, inflight_d;

  redirect_src_e    src_s;
  logic             redirect_s;
  logic [XLEN-1:0]  target_s;
  logic             valid_s;
  logic             handshake_s;
  logic             pop_s;
  logic             push_s;
  logic             issue_s;
  logic [PTR_W+1:0] credit_s;
  logic [PTR_W:0]   count_s;
  fq_entry_t        head_s;
  fq_entry_t        push_entry_s;

  // Redirect resolution, credit check and the control strobes for the queue.
  always_comb begin
    src_s        = redirect_select(jalr, UJ_en, b_en);
    redirect_s   = (src_s != RS_NONE);
    target_s     = redirect_target(src_s, branch_pc, al, UJimm, SBimm);
    valid_s      = (count_s != '0);
    handshake_s  = valid_s && bus.out_ready;
    // A redirect discards the queue, so a same-cycle pop must not advance it.
    pop_s        = handshake_s && !redirect_s;
    credit_s     = {1'b0, count_s} + (PTR_W+2)'(inflight_q)
                 - (PTR_W+2)'(handshake_s);
    issue_s      = !reset && !redirect_s && (credit_s < (PTR_W+2)'(DEPTH));
    // The read issued last cycle returns now; a redirect kills it.
    push_s       = inflight_q && !redirect_s && !reset;
    push_entry_s = '{pc: req_pc_q, inst: bus.imem_rdata};
  end

  // Fetch PC and in-flight request bookkeeping.
  always_comb begin
    fpc_d      = fpc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue_s;
    if (redirect_s) begin
      fpc_d = target_s;
    end else if (issue_s) begin
      fpc_d    = fpc_q + XLEN'(4);
      req_pc_d = fpc_q;
    end else begin
      fpc_d = fpc_q;
    end
  end

  // Fetch-side registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q      <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      fpc_q      <= fpc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .flush      (redirect_s),
    .head       (head_s),
    .count      (count_s)
  );

  assign bus.imem_en   = issue_s;
  assign bus.imem_adr  = fpc_q[ADDR_W+1:2];
  assign bus.out_valid = valid_s;
  assign bus.out_inst  = valid_s ? head_s.inst : '0;
  assign bus.out_pc    = valid_s ? head_s.pc   : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a memory model returns 0x1000_0000 + word
// address, and a scoreboard of expected PCs is drained against the decode
// handshake.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        b_en, UJ_en, jalr;
  logic [31:0] branch_pc, al, UJimm, SBimm;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb [$];
  int          n_issue;

  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(32), .ADDR_W(12)) bus ();

  fetch_queue #(
    .XLEN(32), .ADDR_W(12), .DEPTH(4), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .b_en      (b_en),
    .UJ_en     (UJ_en),
    .jalr      (jalr),
    .branch_pc (branch_pc),
    .al        (al),
    .UJimm     (UJimm),
    .SBimm     (SBimm),
    .bus       (bus)
  );

  // Synchronous instruction memory: word n holds 0x1000_0000 + n.
  always @(posedge clk) begin
    bus.imem_rdata <= bus.imem_en ? (32'h1000_0000 + {20'h0, bus.imem_adr})
                                  : 32'hDEAD_BEEF;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_run(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back(base + 32'(4 * i));
    end
  endtask

  // Pop and compare on every accepted head; bounded by max_cycles.
  task automatic drain(input int max_cycles, input int exp_cycles);
    int          n;
    logic [31:0] pc;
    n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      if (bus.out_valid && bus.out_ready) begin
        pc = sb.pop_front();
        chk("out_pc", bus.out_pc, pc);
        chk("out_inst", bus.out_inst, 32'h1000_0000 + ((pc >> 2) & 32'h0000_0FFF));
      end
      step();
      n++;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    if (exp_cycles >= 0) begin
      chk("drain_cycles", 32'(n), 32'(exp_cycles));
    end
    sb.delete();
  endtask

  initial begin
    reset = 1'b1; b_en = 1'b0; UJ_en = 1'b0; jalr = 1'b0;
    branch_pc = 32'h0; al = 32'h0; UJimm = 32'h0; SBimm = 32'h0;
    bus.out_ready = 1'b1;
    step(); step();

    // 1: reset state, then streaming one instruction per cycle
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_imem_en", 32'(bus.imem_en), 32'd0);
    chk("rst_out_inst", bus.out_inst, 32'h0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    reset = 1'b0; #1;
    chk("c0_imem_en", 32'(bus.imem_en), 32'd1);
    chk("c0_imem_adr", 32'(bus.imem_adr), 32'd0);
    step();
    chk("c1_imem_adr", 32'(bus.imem_adr), 32'd1);
    chk("c1_out_valid", 32'(bus.out_valid), 32'd0);
    step();
    chk("c2_imem_adr", 32'(bus.imem_adr), 32'd2);
    chk("c2_out_valid", 32'(bus.out_valid), 32'd1);
    expect_run(32'h0, 8);
    drain(40, 8);

    // 2: decode stalled -> exactly DEPTH issues, then ordered release
    reset = 1'b1; step();
    reset = 1'b0; bus.out_ready = 1'b0; #1;
    n_issue = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.imem_en) n_issue++;
      step();
    end
    chk("full_issues", 32'(n_issue), 32'd4);
    chk("full_imem_en", 32'(bus.imem_en), 32'd0);
    chk("full_out_valid", 32'(bus.out_valid), 32'd1);
    chk("full_out_pc", bus.out_pc, 32'h0);
    bus.out_ready = 1'b1; #1;
    expect_run(32'h0, 5);
    drain(20, 5);

    // 3: JALR with 3 queued and one read in flight
    reset = 1'b1; bus.out_ready = 1'b0; step();
    reset = 1'b0; #1;
    step(); step(); step(); step();
    chk("pre_jalr_valid", 32'(bus.out_valid), 32'd1);
    jalr = 1'b1; al = 32'h0000_0103; #1;
    chk("redir_no_issue", 32'(bus.imem_en), 32'd0);
    step();
    jalr = 1'b0; bus.out_ready = 1'b1; #1;
    chk("jalr_flushed", 32'(bus.out_valid), 32'd0);
    chk("jalr_imem_en", 32'(bus.imem_en), 32'd1);
    chk("jalr_imem_adr", 32'(bus.imem_adr), 32'h40);
    step();
    chk("jalr_killed", 32'(bus.out_valid), 32'd0);
    step();
    chk("jalr_valid", 32'(bus.out_valid), 32'd1);
    expect_run(32'h100, 3);
    drain(20, 3);

    // 4: priority jalr > UJ > SB, then UJ > SB
    jalr = 1'b1; al = 32'h0000_0200; UJ_en = 1'b1; b_en = 1'b1;
    branch_pc = 32'h20; UJimm = 32'h40; SBimm = 32'hFFFF_FFF8; #1;
    step();
    jalr = 1'b0; #1;
    chk("prio_jalr_adr", 32'(bus.imem_adr), 32'h80);
    step();
    UJ_en = 1'b0; b_en = 1'b0; #1;
    chk("prio_uj_adr", 32'(bus.imem_adr), 32'h18);
    chk("prio_uj_en", 32'(bus.imem_en), 32'd1);
    expect_run(32'h60, 3);
    drain(20, -1);

    // 5: branch target wraps below zero
    b_en = 1'b1; branch_pc = 32'h4; SBimm = 32'hFFFF_FFF8; #1;
    step();
    b_en = 1'b0; #1;
    chk("wrap_adr", 32'(bus.imem_adr), 32'hFFF);
    chk("wrap_en", 32'(bus.imem_en), 32'd1);
    expect_run(32'hFFFF_FFFC, 3);
    drain(20, -1);

    // 6: reset mid-stream discards queue and in-flight read
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    reset = 1'b1; #1;
    chk("rst_hold_en", 32'(bus.imem_en), 32'd0);
    step();
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_en", 32'(bus.imem_en), 32'd0);
    reset = 1'b0; #1;
    chk("restart_adr", 32'(bus.imem_adr), 32'h0);
    chk("restart_en", 32'(bus.imem_en), 32'd1);
    expect_run(32'h0, 3);
    drain(20, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
